// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter feeding one registered output stage (round-robin by default).
// Define ARB_MUX_FIXED_PRIO_EN to select lowest-index-wins fixed priority instead.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    // Handshake: a beat moves on a port when its valid and ready are both 1 at a
    // rising edge; valid never waits on ready, and in_ready never looks at in_data.

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic             load;
    logic             gnt_found;
    logic [SEL_W-1:0] gnt_idx;

    // The output stage may take a new beat when empty or being drained this cycle.
    assign load = ~out_valid_q | out_ready;

`ifdef ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = SEL_W'(i);
            end
        end
    end
`else
    // Scan from last+N down to last+1 so the channel nearest after last wins.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N;
            if (in_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end
`endif

    always_comb begin
        in_ready = '0;
        if (reset && load && gnt_found) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (load) begin
            if (gnt_found) begin
                out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                out_sel_d   = gnt_idx;
                out_valid_d = 1'b1;
                last_d      = gnt_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // last resets to N-1 so channel 0 holds first priority after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SEL_W'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning data width in bits of every channel and the output.
REQ-002 The module SHALL have parameter N, default 4, legal range 2..8, meaning number of input channels.
REQ-003 The module SHALL have parameter SEL_W, default 2, meaning output channel-index width, required equal to ceil(log2(N)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset: sampled only on rising clk, asserted when 0.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  bit i high: channel i offers a beat.
REQ-008 in_ready  output  N  bit i high: channel i beat accepted this cycle.
REQ-009 out_data  output  WIDTH  registered selected beat.
REQ-010 out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a beat.
REQ-012 out_ready  input  1  downstream accepts the beat when high together with out_valid.

Function
REQ-013 A beat SHALL transfer on an input channel i in a cycle where in_valid[i] and in_ready[i] are both 1, and on the output in a cycle where out_valid and out_ready are both 1.
REQ-014 The output register SHALL be loadable in a cycle iff out_valid==0 or out_ready==1 (signal "load").
REQ-015 in_ready SHALL be one-hot or zero, with in_ready[g]=1 only when load==1, in_valid[g]==1, and g is the granted channel.
REQ-016 in_ready SHALL depend only on in_valid, out_valid, out_ready and internal state, never on in_data.
REQ-017 Grant SHALL be round-robin: g is the first i with in_valid[i]==1, searching from (last+1) mod N upward with wrap-around, where last is the internal pointer.
REQ-018 On a transfer from channel g, the next edge SHALL load out_data=in_data[g], out_sel=g and out_valid=1, and SHALL set last=g.
REQ-019 If load==1 and no in_valid is set, the next edge SHALL clear out_valid and leave out_data, out_sel and last unchanged.
REQ-020 If out_valid==1 and out_ready==0, out_data, out_sel, out_valid and last SHALL hold, and in_ready SHALL be all zero.
REQ-021 Latency SHALL be one cycle input-to-output.
REQ-022 Throughput SHALL be one beat per cycle when out_ready stays 1 (pop and push in the same cycle).
REQ-023 A channel whose in_valid drops before being granted SHALL lose nothing; the arbiter SHALL re-evaluate every cycle.
REQ-024 With all N channels continuously valid, grants SHALL cycle 0,1,...,N-1,0,... with no channel starved longer than N-1 transfers.

Reset
REQ-025 While reset==0 at an edge, out_valid SHALL become 0, out_data 0, out_sel 0 and last N-1, so channel 0 has first priority.
REQ-026 While reset==0, in_ready SHALL be all zero.
REQ-027 A beat held mid-operation when reset asserts SHALL be discarded.
REQ-028 Reset SHALL take precedence over any simultaneous transfer.

Configuration
REQ-029 When macro ARB_MUX_FIXED_PRIO_EN is defined, grant SHALL be fixed priority: lowest-index valid channel wins, and last SHALL be unused (still reset, never read).
REQ-030 When ARB_MUX_FIXED_PRIO_EN is undefined, round-robin per REQ-017 SHALL apply.
REQ-031 All other behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset: hold reset=0 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
REQ-033 Round-robin: N=4, in_valid=4'b1111, in_data ch i = 32'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 32'hA0..A3,A0.
REQ-034 Backpressure: beat from ch2 (32'h55) loaded, out_ready=0 3 cycles -> out_data=32'h55, out_sel=2 stable, in_ready=0; out_ready=1 -> next grant ch3 if valid.
REQ-035 Wrap/skip: last=3, in_valid=4'b0100 -> in_ready=4'b0100, out_sel=2; then in_valid=0 with out_ready=1 -> out_valid=0.
REQ-036 Reset mid-stream: out_valid=1, out_ready=0, reset=0 one cycle -> out_valid=0; next grant with in_valid=4'b1010 goes to ch1.
REQ-037 Fixed-priority build: in_valid=4'b1111 for 3 cycles, out_ready=1 -> out_sel=0 every cycle, in_ready=4'b0001.
